// File: rtl/ascon_pack.sv
// Shared ASCON definitions: the 320-bit state type, round bookkeeping,
// the round-constant function and the permutation FSM encoding.
package ascon_pack;

    // Row r of the state is element [r]; row 0 is x0.
    typedef logic [4:0][63:0] type_state;

    localparam logic [3:0] ROUND_LAST = 4'd11;

    // Linear-layer rotation amounts for rows x0..x4.
    localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perm_fsm_t;

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/perm_engine_if.sv
// Start/result handshake between the mode FSM (master) and the permutation engine (slave).
interface perm_engine_if
    import ascon_pack::*;
();
    logic       start_i;
    logic       mode_i;
    type_state  state_i;
    logic       ready_o;
    logic       busy_o;
    logic [3:0] round_o;
    logic       valid_o;
    type_state  state_o;

    modport master (
        output start_i, mode_i, state_i,
        input  ready_o, busy_o, round_o, valid_o, state_o
    );

    modport slave (
        input  start_i, mode_i, state_i,
        output ready_o, busy_o, round_o, valid_o, state_o
    );
endinterface

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced 5-bit S-box, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    type_state sub_s;
    type_state chi_t;

    always_comb begin
        sub_s    = state_i;
        sub_s[2] = sub_s[2] ^ {56'd0, round_const(round_i)};

        sub_s[0] = sub_s[0] ^ sub_s[4];
        sub_s[4] = sub_s[4] ^ sub_s[3];
        sub_s[2] = sub_s[2] ^ sub_s[1];
        // Chi-like step: each row picks up (~row & next_row) of its neighbour.
        for (int i = 0; i < 5; i++) begin
            chi_t[i] = ~sub_s[i] & sub_s[(i + 1) % 5];
        end
        for (int i = 0; i < 5; i++) begin
            sub_s[i] = sub_s[i] ^ chi_t[(i + 1) % 5];
        end
        sub_s[1] = sub_s[1] ^ sub_s[0];
        sub_s[0] = sub_s[0] ^ sub_s[4];
        sub_s[3] = sub_s[3] ^ sub_s[2];
        sub_s[2] = ~sub_s[2];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_lin
            assign state_o[gi] = sub_s[gi]
                               ^ ror64(sub_s[gi], ROT_A[gi])
                               ^ ror64(sub_s[gi], ROT_B[gi]);
        end
    endgenerate

endmodule

// File: rtl/perm_engine.sv
// Iterative ASCON permutation: one round per clock over a 320-bit state register,
// running p^a (12 rounds) or p^b (PB_ROUNDS rounds) under a start/valid handshake.
module perm_engine
    import ascon_pack::*;
#(
    parameter int unsigned PB_ROUNDS = 6
) (
    input  logic          clock_i,
    input  logic          resetb_i,
    perm_engine_if.slave  bus
);

    localparam logic [3:0] START_B = 4'(12 - PB_ROUNDS);

    perm_fsm_t  fsm_q;
    type_state  state_q;
    type_state  state_d;
    logic [3:0] round_q;
    logic       ready_q;
    logic       busy_q;
    logic       valid_q;

    ascon_round u_round (
        .state_i (state_q),
        .round_i (round_q),
        .state_o (state_d)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            round_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts a new start directly so back-to-back runs have no bubble.
                    if (bus.start_i) begin
                        state_q <= bus.state_i;
                        round_q <= bus.mode_i ? START_B : 4'd0;
                        fsm_q   <= ST_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        fsm_q   <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                    valid_q <= 1'b0;
                end
                ST_RUN: begin
                    state_q <= state_d;
                    if (round_q == ROUND_LAST) begin
                        fsm_q   <= ST_DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.busy_o  = busy_q;
    assign bus.valid_o = valid_q;
    assign bus.round_o = round_q;
    assign bus.state_o = state_q;

endmodule

// File: doc/perm_engine.md
Name: perm_engine

Overview:
- Iterative ASCON permutation engine: one full round per clock, in the order constant addition, then substitution, then linear diffusion.
- Wraps the existing combinational round layers around a 320-bit state register.
- Runs p^a (12 rounds) or p^b (PB_ROUNDS rounds) under a start/valid handshake.
- Sits between the mode FSM (init/AD/plaintext/finalisation) and the state datapath; it is the sole consumer of the substitution layer's output.

Parameters:
- PB_ROUNDS, 6, number of rounds for p^b. Legal range 1..12. Start round index is 12-PB_ROUNDS.

Ports:
- clock_i  input  1  system clock; rising edge active.
- resetb_i  input  1  asynchronous reset, active-low.
- start_i  input  1  request a permutation; sampled only when ready_o=1.
- mode_i  input  1  0 = p^a (12 rounds), 1 = p^b (PB_ROUNDS rounds); sampled with start_i.
- state_i  input  type_state (5x64)  input state; sampled with start_i.
- ready_o  output  1  engine can accept start_i (IDLE or DONE).
- busy_o  output  1  rounds in progress (RUN).
- round_o  output  4  round index being applied this cycle (0..11).
- valid_o  output  1  one-cycle pulse: state_o holds the permuted state.
- state_o  output  type_state  registered result; stable until the next accepted start.

Behaviour:
- Reset (resetb_i low, asynchronous): FSM=IDLE, state register=0, round counter=0. Outputs: ready_o=1, busy_o=0, valid_o=0, round_o=0, state_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1: load state_i into the state register. round <= 0 if mode_i=0, else 12-PB_ROUNDS. Go to RUN.
- RUN, each edge: state <= pl(ps(pc(state, round))).
  - round_o shows the index used in that update.
  - Round constant for index r is {4'hF-r, r} (8 bits), XORed into row 2 bits [7:0].
  - If round==11, go to DONE; else round <= round+1.
- DONE: valid_o=1 for exactly this one cycle; ready_o=1.
  - start_i=1: load exactly as from IDLE and go to RUN (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
- Latency, with start accepted at edge k:
  - p^a: valid_o is high in the cycle after edge k+12; 13 clocks start-to-valid.
  - p^b (default): valid_o after edge k+PB_ROUNDS; 7 clocks.
- state_o is driven directly from the state register.
  - In RUN it shows intermediate states; consumers use it only when valid_o=1 or when in IDLE.
  - In IDLE, state_o holds the last result.
- start_i while busy_o=1: ignored, with no effect on the state, round counter or mode. The requester must hold start_i until ready_o=1.
- Round counter: 4 bits. Never exceeds 11; no wrap-around in RUN.
- mode_i and state_i are don't-care when no start is accepted.
- Reset asserted mid-RUN: immediate return to IDLE with the state cleared. No valid_o pulse, including on reset release.
- All outputs are registered or decoded from FSM state only; no combinational path from inputs to outputs.

Decomposition:
- ascon_pack (shared package):
  - type_state.
  - ROUND_LAST=11 constant.
  - Round-constant function, index -> 8-bit constant.
  - FSM state enum type.
- Sub-module ascon_round: purely combinational. Inputs are the state and a 4-bit round index; output is the next state. It chains pc, the existing ps, and pl.
- perm_engine contains only the FSM, the round counter and the state register.

Test Plan:
- Reset: hold resetb_i=0 for 3 cycles, release -> ready_o=1, busy_o=0, valid_o=0, round_o=0, state_o all zeros.
- p^a on a known state:
  - Stimulus: start_i=1 with mode_i=0 and state_i = ASCON-128 init state, i.e. IV 80400c0600000000, key 000102..0f, nonce 000102..0f.
  - Required: round_o steps 0..11 on consecutive cycles; valid_o rises 13 clocks after start; state_o matches the golden-model permutation bit-exactly; valid_o is high for exactly 1 cycle.
- p^b:
  - Stimulus: start with mode_i=1 on the same state.
  - Required: round_o steps 6..11; valid_o after 7 clocks; state_o equals the golden p^b result.
- Start while busy:
  - Stimulus: pulse start_i with different state_i at rounds 3 and 7 of a p^a run.
  - Required: no effect; the result is identical to the undisturbed run; ready_o=0 throughout RUN.
- Back-to-back: assert start_i in the DONE cycle -> the next run begins with no IDLE cycle; both results are correct; valid_o pulses 13 clocks apart.
- Mid-run reset:
  - Stimulus: assert resetb_i at round 5 for 1 cycle.
  - Required: immediate IDLE and state_o=0; no valid_o pulse; a subsequent p^a run completes correctly.
